// File: rtl/perc_pkg.sv
// Shared types and helpers for the perceptron weight store.
package perc_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPDATE
    } state_e;

    // Width of a dot product of hist_len+1 weights of w_bits each, signed.
    function automatic int unsigned sum_width(input int unsigned w_bits,
                                              input int unsigned hist_len);
        return w_bits + $clog2(hist_len + 1);
    endfunction

    // Add a +/-1 step to a w_bits-wide signed weight, clamping to its range.
    function automatic int sat_add(input int w, input int step, input int unsigned w_bits);
        int hi;
        int lo;
        int r;
        hi = (1 << (w_bits - 1)) - 1;
        lo = -(1 << (w_bits - 1));
        r  = w + step;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/perc_dot.sv
// Combinational perceptron dot product: bias plus +/- weight per history bit.
module perc_dot #(
    parameter int unsigned W_BITS   = 8,
    parameter int unsigned HIST_LEN = 12,
    parameter int unsigned SUM_W    = 12
) (
    input  logic [HIST_LEN:0][W_BITS-1:0] w_i,
    input  logic [HIST_LEN-1:0]           hist_i,
    output logic signed [SUM_W-1:0]       sum_o
);

    logic [HIST_LEN:0]        sel;
    logic signed [W_BITS-1:0] wv;
    logic signed [SUM_W-1:0]  ext;
    logic signed [SUM_W-1:0]  acc;

    // Bias always adds; weight i+1 adds when history bit i is set, else subtracts.
    always_comb begin
        sel = {hist_i, 1'b1};
        acc = '0;
        wv  = '0;
        ext = '0;
        for (int k = 0; k <= int'(HIST_LEN); k++) begin
            wv  = w_i[k];
            ext = SUM_W'(wv);
            acc = sel[k] ? (acc + ext) : (acc - ext);
        end
        sum_o = acc;
    end

endmodule

// File: rtl/perc_train_table.sv
// Perceptron weight table with registered prediction and a one-request RMW trainer.
module perc_train_table
    import perc_pkg::*;
#(
    parameter int unsigned W_BITS   = 8,
    parameter int unsigned HIST_LEN = 12,
    parameter int unsigned B_SETS   = 4,
    parameter int unsigned THETA    = 37,
    localparam int unsigned SUM_W   = sum_width(W_BITS, HIST_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pred_valid_i,
    input  logic [B_SETS-1:0]       pred_index_i,
    input  logic [HIST_LEN-1:0]     pred_hist_i,
    output logic                    pred_valid_o,
    output logic signed [SUM_W-1:0] pred_sum_o,
    output logic                    pred_taken_o,
    input  logic                    train_valid_i,
    output logic                    train_ready_o,
    input  logic [B_SETS-1:0]       train_index_i,
    input  logic [HIST_LEN-1:0]     train_hist_i,
    input  logic                    train_taken_i,
    input  logic [SUM_W-1:0]        train_sum_i,
    output logic                    init_done_o
);

    localparam int unsigned N_SETS = 2 ** B_SETS;
    localparam logic [SUM_W:0] THETA_W = (SUM_W + 1)'(THETA);

    typedef logic [HIST_LEN:0][W_BITS-1:0] row_t;

    row_t tbl_q [N_SETS];

    state_e              state_q, state_d;
    logic [B_SETS-1:0]   clr_q, clr_d;
    logic                init_done_q, init_done_d;
    logic [B_SETS-1:0]   trn_idx_q, trn_idx_d;
    logic [HIST_LEN-1:0] trn_hist_q, trn_hist_d;
    logic                trn_taken_q, trn_taken_d;
    logic [SUM_W-1:0]    trn_sum_q, trn_sum_d;

    logic                    pred_valid_q, pred_valid_d;
    logic signed [SUM_W-1:0] pred_sum_q, pred_sum_d;
    logic                    pred_taken_q, pred_taken_d;

    logic                     wr_en;
    logic [B_SETS-1:0]        wr_idx;
    row_t                     wr_row;
    row_t                     row_cur;
    row_t                     row_upd;
    row_t                     pred_row;
    logic [HIST_LEN:0]        up;
    logic signed [W_BITS-1:0] wv;
    logic [SUM_W:0]           sum_ext;
    logic [SUM_W:0]           mag;
    logic                     mispred;
    logic                     do_train;
    logic signed [SUM_W-1:0]  dot_sum;

    // Training decision and the saturated post-update row for the latched set.
    always_comb begin
        sum_ext  = {trn_sum_q[SUM_W-1], trn_sum_q};
        mag      = trn_sum_q[SUM_W-1] ? (~sum_ext + 1'b1) : sum_ext;
        // Sum sign bit equal to the outcome means the predicted direction was wrong.
        mispred  = (trn_sum_q[SUM_W-1] == trn_taken_q);
        do_train = mispred || (mag <= THETA_W);
        // up[k] set means weight k moves by +1, otherwise by -1.
        up       = {~(trn_hist_q ^ {HIST_LEN{trn_taken_q}}), trn_taken_q};
        row_cur  = tbl_q[trn_idx_q];
        row_upd  = row_cur;
        wv       = '0;
        for (int k = 0; k <= int'(HIST_LEN); k++) begin
            wv         = row_cur[k];
            row_upd[k] = W_BITS'(sat_add(int'(wv), up[k] ? 1 : -1, W_BITS));
        end
    end

    // FSM next state, request latch and table write port.
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        init_done_d = init_done_q;
        trn_idx_d   = trn_idx_q;
        trn_hist_d  = trn_hist_q;
        trn_taken_d = trn_taken_q;
        trn_sum_d   = trn_sum_q;
        wr_en       = 1'b0;
        wr_idx      = clr_q;
        wr_row      = '0;
        unique case (state_q)
            INIT: begin
                wr_en  = 1'b1;
                wr_idx = clr_q;
                clr_d  = clr_q + 1'b1;
                if (clr_q == B_SETS'(N_SETS - 1)) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (train_valid_i) begin
                    trn_idx_d   = train_index_i;
                    trn_hist_d  = train_hist_i;
                    trn_taken_d = train_taken_i;
                    trn_sum_d   = train_sum_i;
                    state_d     = UPDATE;
                end
            end
            UPDATE: begin
                wr_en   = do_train;
                wr_idx  = trn_idx_q;
                wr_row  = row_upd;
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // Prediction read with write-first forwarding from an in-flight update.
    always_comb begin
        pred_row = tbl_q[pred_index_i];
        if (state_q == UPDATE && do_train && trn_idx_q == pred_index_i) begin
            pred_row = row_upd;
        end
    end

    perc_dot #(
        .W_BITS  (W_BITS),
        .HIST_LEN(HIST_LEN),
        .SUM_W   (SUM_W)
    ) u_dot (
        .w_i   (pred_row),
        .hist_i(pred_hist_i),
        .sum_o (dot_sum)
    );

    // Prediction result; held when no request, forced neutral while clearing.
    always_comb begin
        pred_valid_d = pred_valid_i;
        pred_sum_d   = pred_sum_q;
        pred_taken_d = pred_taken_q;
        if (pred_valid_i) begin
            if (state_q == INIT) begin
                pred_sum_d   = '0;
                pred_taken_d = 1'b1;
            end else begin
                pred_sum_d   = dot_sum;
                pred_taken_d = ~dot_sum[SUM_W-1];
            end
        end
    end

    // Control and output registers; reset drops any latched request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            clr_q        <= '0;
            init_done_q  <= 1'b0;
            trn_idx_q    <= '0;
            trn_hist_q   <= '0;
            trn_taken_q  <= 1'b0;
            trn_sum_q    <= '0;
            pred_valid_q <= 1'b0;
            pred_sum_q   <= '0;
            pred_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_q        <= clr_d;
            init_done_q  <= init_done_d;
            trn_idx_q    <= trn_idx_d;
            trn_hist_q   <= trn_hist_d;
            trn_taken_q  <= trn_taken_d;
            trn_sum_q    <= trn_sum_d;
            pred_valid_q <= pred_valid_d;
            pred_sum_q   <= pred_sum_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    // Weight storage; contents are established by the INIT sweep, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_q[wr_idx] <= wr_row;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_sum_o    = pred_sum_q;
    assign pred_taken_o  = pred_taken_q;
    assign train_ready_o = (state_q == IDLE);
    assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_perc_train_table.sv
// Scoreboard bench for perc_train_table with hand-computed directed vectors.
module tb_perc_train_table;

    localparam int SUM_W = 12;

    typedef struct packed {
        logic signed [SUM_W-1:0] sum;
        logic                    taken;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    pred_valid_i = 1'b0;
    logic [3:0]              pred_index_i = '0;
    logic [11:0]             pred_hist_i = '0;
    logic                    pred_valid_o;
    logic signed [SUM_W-1:0] pred_sum_o;
    logic                    pred_taken_o;
    logic                    train_valid_i = 1'b0;
    logic                    train_ready_o;
    logic [3:0]              train_index_i = '0;
    logic [11:0]             train_hist_i = '0;
    logic                    train_taken_i = 1'b0;
    logic [SUM_W-1:0]        train_sum_i = '0;
    logic                    init_done_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    perc_train_table dut (
        .clk          (clk),
        .rst          (rst),
        .pred_valid_i (pred_valid_i),
        .pred_index_i (pred_index_i),
        .pred_hist_i  (pred_hist_i),
        .pred_valid_o (pred_valid_o),
        .pred_sum_o   (pred_sum_o),
        .pred_taken_o (pred_taken_o),
        .train_valid_i(train_valid_i),
        .train_ready_o(train_ready_o),
        .train_index_i(train_index_i),
        .train_hist_i (train_hist_i),
        .train_taken_i(train_taken_i),
        .train_sum_i  (train_sum_i),
        .init_done_o  (init_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int sum, input bit taken);
        exp_t e;
        e.sum   = SUM_W'(sum);
        e.taken = taken;
        exp_q.push_back(e);
    endtask

    // Called one step after a rising edge; occupies exactly one cycle.
    task automatic predict(input int idx, input logic [11:0] hist, input int sum, input bit taken);
        push_exp(sum, taken);
        pred_valid_i = 1'b1;
        pred_index_i = 4'(idx);
        pred_hist_i  = hist;
        @(posedge clk); #1;
        pred_valid_i = 1'b0;
    endtask

    task automatic train(input int idx, input logic [11:0] hist, input bit taken, input int sum);
        int n;
        n = 0;
        while (!train_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("train_ready_wait", int'(train_ready_o), 1);
        train_valid_i = 1'b1;
        train_index_i = 4'(idx);
        train_hist_i  = hist;
        train_taken_i = taken;
        train_sum_i   = SUM_W'(sum);
        @(posedge clk); #1;
        train_valid_i = 1'b0;
    endtask

    task automatic init_wait();
        for (int i = 0; i < 16; i++) begin
            check("init_done_low", int'(init_done_o), 0);
            check("init_ready_low", int'(train_ready_o), 0);
            @(posedge clk); #1;
        end
        check("init_done_high", int'(init_done_o), 1);
        check("idle_ready_high", int'(train_ready_o), 1);
    endtask

    // Monitor: every valid prediction result is matched against the scoreboard.
    always @(negedge clk) begin
        if (pred_valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pred_unexpected: got sum %0d with no expected entry", pred_sum_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (pred_sum_o !== e.sum || pred_taken_o !== e.taken) begin
                    n_bad++;
                    $display("FAIL pred_result: got sum %0d taken %0b expected sum %0d taken %0b",
                             pred_sum_o, pred_taken_o, e.sum, e.taken);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc;
        logic rdy;

        // 1: reset, prediction during INIT, reset mid-INIT, full INIT length
        repeat (3) @(posedge clk);
        #1;
        check("reset_pred_valid", int'(pred_valid_o), 0);
        check("reset_pred_sum", int'(pred_sum_o), 0);
        check("reset_pred_taken", int'(pred_taken_o), 0);
        check("reset_ready", int'(train_ready_o), 0);
        check("reset_init_done", int'(init_done_o), 0);
        rst = 1'b0;
        predict(9, 12'hABC, 0, 1'b1);
        repeat (4) begin
            check("early_init_done", int'(init_done_o), 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("mid_init_rst_ready", int'(train_ready_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        init_wait();

        // 2: basic train and predictions
        train(3, 12'hFFF, 1'b1, 0);
        predict(3, 12'hFFF, 13, 1'b1);
        predict(3, 12'h000, -11, 1'b0);
        predict(4, 12'hFFF, 0, 1'b1);

        // 3: saturation at both ends
        for (int i = 0; i < 130; i++) train(5, 12'hFFF, 1'b1, 0);
        predict(5, 12'hFFF, 1651, 1'b1);
        for (int i = 0; i < 300; i++) train(5, 12'hFFF, 1'b0, 0);
        predict(5, 12'hFFF, -1664, 1'b0);

        // 4: threshold rule
        train(7, 12'hFFF, 1'b1, 38);
        predict(7, 12'hFFF, 0, 1'b1);
        train(7, 12'hFFF, 1'b1, 37);
        predict(7, 12'hFFF, 13, 1'b1);
        train(7, 12'hFFF, 1'b1, -200);
        predict(7, 12'hFFF, 26, 1'b1);
        train(7, 12'hFFF, 1'b0, -2048);
        predict(7, 12'hFFF, 26, 1'b1);

        // 5: back-to-back requests and forwarding in UPDATE
        train_valid_i = 1'b1;
        train_index_i = 4'd10;
        train_hist_i  = 12'hFFF;
        train_taken_i = 1'b1;
        train_sum_i   = '0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            check("hs_ready", int'(train_ready_o), (c % 2 == 0) ? 1 : 0);
            rdy = train_ready_o;
            if (c == 1 || c == 7) begin
                push_exp((c == 1) ? 13 : 52, 1'b1);
                pred_valid_i = 1'b1;
                pred_index_i = 4'd10;
                pred_hist_i  = 12'hFFF;
            end else begin
                pred_valid_i = 1'b0;
            end
            @(posedge clk); #1;
            if (rdy) begin
                acc++;
                if (acc == 4) train_valid_i = 1'b0;
            end
        end
        pred_valid_i = 1'b0;
        check("hs_accepts", acc, 4);

        // 6: reset during UPDATE drops the write; table re-cleared
        train_valid_i = 1'b1;
        train_index_i = 4'd2;
        train_hist_i  = 12'hFFF;
        train_taken_i = 1'b1;
        train_sum_i   = '0;
        @(posedge clk); #1;
        train_valid_i = 1'b0;
        check("update_ready_low", int'(train_ready_o), 0);
        rst = 1'b1;
        #1;
        check("rst_init_done_clear", int'(init_done_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        init_wait();
        predict(2, 12'hFFF, 0, 1'b1);
        predict(3, 12'hFFF, 0, 1'b1);
        predict(10, 12'hFFF, 0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perc_train_table.md
Name: perc_train_table

Overview:
- Next-generation perceptron weight store with integrated prediction and training.
- Holds 2**B_SETS perceptrons of HIST_LEN+1 signed weights; index 0 is the bias.
- Prediction path: registered dot product (sum plus taken bit) from set index and global history.
- Training path: valid/ready read-modify-write engine; applies the threshold rule and saturating weight update internally.
- Replaces external RMW logic between the fetch and EX/MEM stages.

Parameters:
W_BITS, 8, weight width, signed two's complement
HIST_LEN, 12, global history length; weights per set = HIST_LEN+1
B_SETS, 4, index width; N_SETS = 2**B_SETS
THETA, 37, training threshold, nonnegative integer
(derived) SUM_W = W_BITS + $clog2(HIST_LEN+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pred_valid_i  in  1  prediction lookup request
pred_index_i  in  B_SETS  set to read
pred_hist_i  in  HIST_LEN  history; bit i selects weight i+1
pred_valid_o  out  1  result valid, one cycle after request
pred_sum_o  out  SUM_W  signed perceptron output
pred_taken_o  out  1  pred_sum_o >= 0
train_valid_i  in  1  training request
train_ready_o  out  1  engine can accept a request
train_index_i  in  B_SETS  set to train
train_hist_i  in  HIST_LEN  history used at prediction time
train_taken_i  in  1  resolved outcome
train_sum_i  in  SUM_W  sum returned at prediction time
init_done_o  out  1  table clear complete

Behaviour:
- Reset values: pred_valid_o=0, pred_sum_o=0, pred_taken_o=0, train_ready_o=0, init_done_o=0; FSM enters INIT with clear counter at 0.
- FSM states: INIT, IDLE, UPDATE.
- INIT:
  - Clears one set per cycle, sets 0..N_SETS-1.
  - Moves to IDLE after clearing set N_SETS-1, so INIT lasts N_SETS cycles.
  - init_done_o is registered: rises on the IDLE entry edge and stays high until rst.
- Prediction, all states, latency 1:
  - On each edge, pred_valid_o <= pred_valid_i.
  - Sum = w[0] + Σ_i (pred_hist_i[i] ? +w[i+1] : −w[i+1]), computed in SUM_W bits; cannot overflow.
  - pred_taken_o = ~sum[SUM_W-1].
  - While in INIT, the result is forced to sum 0, taken 1.
  - If pred_valid_i=0, sum and taken hold their previous values.
- Training handshake:
  - train_ready_o = (state==IDLE).
  - Transfer on train_valid_i && train_ready_o: request latched, IDLE→UPDATE.
  - Single outstanding request; sustained throughput is 1 per 2 cycles.
- UPDATE, exactly one cycle:
  - Reads the latched set and computes the update decision.
  - mispred = (train_sum >= 0) != train_taken.
  - mag = |train_sum|, computed in SUM_W+1 bits so the most-negative value is exact.
  - do_train = mispred || mag <= THETA.
  - If do_train, at the end of the cycle:
    - t = train_taken ? +1 : −1.
    - w[0] += t.
    - w[i+1] += (hist[i] ? t : −t).
    - Each result saturates to [−2^(W_BITS−1), 2^(W_BITS−1)−1].
  - If not do_train, no write.
  - Always returns to IDLE.
- Write-first forwarding: a prediction read during UPDATE of the same index uses the post-update weights.
- Reset mid-operation:
  - Async rst drops any latched training request; no write occurs.
  - Returns to INIT and clears outputs immediately.
  - Clearing restarts from set 0.

Decomposition:
- Package perc_pkg:
  - state enum {INIT, IDLE, UPDATE}.
  - sat_add function: W_BITS weight plus a ±1 step, saturating.
  - SUM_W derivation helper.
- One sub-module perc_dot:
  - Combinational dot product: weights array + history → SUM_W signed sum.
  - Instantiated once on the prediction path.
  - Training uses train_sum_i and does not need it.

Test Plan:
1. Reset and init: rst high 3 cycles, release.
   - init_done_o=0 for 16 cycles, then 1.
   - Predict idx 9 during INIT → sum 0, taken 1.
   - Assert rst mid-INIT → counter restarts, another 16 cycles.
2. Basic train: after init, train idx 3, hist 12'hFFF, taken 1, sum 0.
   - Predict idx 3 hist 12'hFFF → sum 13, taken 1.
   - Predict idx 3 hist 12'h000 → sum −11, taken 0.
   - Predict idx 4 → sum 0.
3. Saturation: 130 identical trains on idx 5 (hist FFF, taken 1, sum 0).
   - All weights end at 127; predict → sum 1651.
   - Then 300 trains with taken 0 → weights −128; predict → sum −1664.
4. Threshold: on cleared idx 7, hist FFF:
   - taken 1, sum 38 → no write (predict sum 0).
   - taken 1, sum 37 → write (sum 13).
   - taken 1, sum −200 → write, mispredict (sum 26).
   - train_sum = most-negative value with taken 0 → no write.
5. Handshake and forwarding:
   - train_valid_i held high with 4 requests → accepted on alternate cycles, ready=0 in each UPDATE cycle.
   - Prediction of the trained index issued in the UPDATE cycle → post-update sum.
6. Reset during UPDATE: accept a train on idx 2, assert rst in the UPDATE cycle.
   - After re-init, predict idx 2 → sum 0.
   - train_ready_o=0 throughout INIT.
